dest_tracker: RTL and testbench

Producer side of the operand-forwarding path. It carries each instruction's destination tag (rd, reg_wr, is_load) down the RR/EX → EX/MR → MR/WB pipeline registers and drives the ex_mr_* / mr_wb_* tags the forwarding logic compares against. It also detects load-use hazards and inserts exactly one bubble per hazard. It keeps a pending-write mask and a saturating stall counter for debug.

---
 rtl/dest_tracker.sv | 116 +++++++++++
 tb/tb_dest_tracker.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_tracker.sv
// Destination-tag pipeline (RR/EX -> EX/MR -> MR/WB) feeding the forwarding
// comparators, with load-use bubble insertion, pending-write mask and stall counter.
module dest_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rr_valid,
  input  logic [2:0]       rr_rd,
  input  logic             rr_reg_wr,
  input  logic             rr_is_load,
  input  logic [2:0]       rr_rs1,
  input  logic [2:0]       rr_rs2,
  input  logic             rr_rs1_used,
  input  logic             rr_rs2_used,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [2:0]       rr_ex_rd,
  output logic             rr_ex_reg_wr,
  output logic             rr_ex_is_load,
  output logic [2:0]       ex_mr_rd,
  output logic             ex_mr_reg_wr,
  output logic [2:0]       mr_wb_rd,
  output logic             mr_wb_reg_wr,
  output logic             stall,
  output logic [7:0]       pending,
  output logic [CNT_W-1:0] stall_count
);

  logic             r_s1_v, r_s1_wr, r_s1_ld;
  logic [2:0]       r_s1_rd;
  logic             r_s2_v, r_s2_wr;
  logic [2:0]       r_s2_rd;
  logic             r_s3_v, r_s3_wr;
  logic [2:0]       r_s3_rd;
  logic [CNT_W-1:0] r_cnt;

  logic             w_rs1_hit, w_rs2_hit, w_hazard, w_bubble;
  logic             w_s1_wr, w_s2_wr, w_s3_wr;
  logic [7:0]       w_pending;

  // R7 sources come from the PC path, so they can never depend on a load.
  assign w_rs1_hit = rr_rs1_used && (rr_rs1 == r_s1_rd) && (rr_rs1 != 3'd7);
  assign w_rs2_hit = rr_rs2_used && (rr_rs2 == r_s1_rd) && (rr_rs2 != 3'd7);
  assign w_hazard  = r_s1_v & r_s1_wr & r_s1_ld & rr_valid & (w_rs1_hit | w_rs2_hit);
  assign w_bubble  = flush | w_hazard;

  assign w_s1_wr = r_s1_v & r_s1_wr;
  assign w_s2_wr = r_s2_v & r_s2_wr;
  assign w_s3_wr = r_s3_v & r_s3_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v  <= 1'b0;
      r_s1_wr <= 1'b0;
      r_s1_ld <= 1'b0;
      r_s1_rd <= 3'd0;
      r_s2_v  <= 1'b0;
      r_s2_wr <= 1'b0;
      r_s2_rd <= 3'd0;
      r_s3_v  <= 1'b0;
      r_s3_wr <= 1'b0;
      r_s3_rd <= 3'd0;
    end else begin
      r_s3_v  <= r_s2_v;
      r_s3_wr <= r_s2_wr;
      r_s3_rd <= r_s2_rd;
      r_s2_v  <= r_s1_v;
      r_s2_wr <= r_s1_wr;
      r_s2_rd <= r_s1_rd;
      if (w_bubble || !rr_valid) begin
        r_s1_v  <= 1'b0;
        r_s1_wr <= 1'b0;
        r_s1_ld <= 1'b0;
        r_s1_rd <= 3'd0;
      end else begin
        r_s1_v  <= 1'b1;
        r_s1_wr <= rr_reg_wr;
        r_s1_ld <= rr_is_load;
        r_s1_rd <= rr_rd;
      end
    end
  end

  // Clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_pending = 8'd0;
    for (int r = 0; r < 8; r++) begin
      w_pending[r] = (w_s1_wr && (r_s1_rd == 3'(r))) ||
                     (w_s2_wr && (r_s2_rd == 3'(r))) ||
                     (w_s3_wr && (r_s3_rd == 3'(r)));
    end
  end

  assign stall         = w_hazard & ~flush;
  assign pending       = w_pending;
  assign stall_count   = r_cnt;
  assign rr_ex_rd      = r_s1_rd;
  assign rr_ex_reg_wr  = w_s1_wr;
  assign rr_ex_is_load = r_s1_v & r_s1_ld;
  assign ex_mr_rd      = r_s2_rd;
  assign ex_mr_reg_wr  = w_s2_wr;
  assign mr_wb_rd      = r_s3_rd;
  assign mr_wb_reg_wr  = w_s3_wr;

endmodule

// File: tb/tb_dest_tracker.sv
// Self-checking bench for dest_tracker: directed scenarios plus randomized
// traffic against a tag-pipeline reference model.
module tb_dest_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rr_valid, rr_reg_wr, rr_is_load, rr_rs1_used, rr_rs2_used, flush, cnt_clr;
  logic [2:0] rr_rd, rr_rs1, rr_rs2;

  logic [2:0]  rr_ex_rd, ex_mr_rd, mr_wb_rd;
  logic        rr_ex_reg_wr, rr_ex_is_load, ex_mr_reg_wr, mr_wb_reg_wr, stall;
  logic [7:0]  pending;
  logic [15:0] stall_count;

  logic [2:0]  rr_ex_rd4, ex_mr_rd4, mr_wb_rd4;
  logic        rr_ex_reg_wr4, rr_ex_is_load4, ex_mr_reg_wr4, mr_wb_reg_wr4, stall4;
  logic [7:0]  pending4;
  logic [3:0]  stall_count4;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       wr;
    logic       ld;
  } tag_t;
  tag_t mstg [3];
  int   mcnt;

  always #5 clk = ~clk;

  dest_tracker #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_rd(rr_rd), .rr_reg_wr(rr_reg_wr),
    .rr_is_load(rr_is_load), .rr_rs1(rr_rs1), .rr_rs2(rr_rs2), .rr_rs1_used(rr_rs1_used),
    .rr_rs2_used(rr_rs2_used), .flush(flush), .cnt_clr(cnt_clr), .rr_ex_rd(rr_ex_rd),
    .rr_ex_reg_wr(rr_ex_reg_wr), .rr_ex_is_load(rr_ex_is_load), .ex_mr_rd(ex_mr_rd),
    .ex_mr_reg_wr(ex_mr_reg_wr), .mr_wb_rd(mr_wb_rd), .mr_wb_reg_wr(mr_wb_reg_wr),
    .stall(stall), .pending(pending), .stall_count(stall_count)
  );

  dest_tracker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_rd(rr_rd), .rr_reg_wr(rr_reg_wr),
    .rr_is_load(rr_is_load), .rr_rs1(rr_rs1), .rr_rs2(rr_rs2), .rr_rs1_used(rr_rs1_used),
    .rr_rs2_used(rr_rs2_used), .flush(flush), .cnt_clr(cnt_clr), .rr_ex_rd(rr_ex_rd4),
    .rr_ex_reg_wr(rr_ex_reg_wr4), .rr_ex_is_load(rr_ex_is_load4), .ex_mr_rd(ex_mr_rd4),
    .ex_mr_reg_wr(ex_mr_reg_wr4), .mr_wb_rd(mr_wb_rd4), .mr_wb_reg_wr(mr_wb_reg_wr4),
    .stall(stall4), .pending(pending4), .stall_count(stall_count4)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rr_valid = 0; rr_rd = 0; rr_reg_wr = 0; rr_is_load = 0;
    rr_rs1 = 0; rr_rs2 = 0; rr_rs1_used = 0; rr_rs2_used = 0;
    flush = 0; cnt_clr = 0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic wr, input logic ld,
                       input logic [2:0] rs1, input logic u1,
                       input logic [2:0] rs2, input logic u2);
    rr_valid = 1; rr_rd = rd; rr_reg_wr = wr; rr_is_load = ld;
    rr_rs1 = rs1; rr_rs1_used = u1; rr_rs2 = rs2; rr_rs2_used = u2;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    do_reset();
    issue(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd4, 1, 0, 3'd2, 1, 3'd0, 0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_pre_stall: got %0b expected 1", stall);
    end
    #1 rst = 1;
    #1;
    obs = {stall, rr_ex_rd, rr_ex_reg_wr, rr_ex_is_load, ex_mr_rd, ex_mr_reg_wr,
           mr_wb_rd, mr_wb_reg_wr, pending};
    checks++;
    if (obs !== 20'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_count: got %0d expected 0", stall_count);
    end
    @(negedge clk);
    rst = 0;
    cyc();
    idle();
    checks++;
    if ({rr_ex_rd, rr_ex_reg_wr} !== {3'd4, 1'b1}) begin
      errors++; $display("[TB] FAIL reset_first_load: got rd=%0d wr=%0b expected rd=4 wr=1",
                         rr_ex_rd, rr_ex_reg_wr);
    end
  endtask

  task automatic test_latency();
    do_reset();
    issue(3'd3, 1, 0, 3'd0, 0, 3'd0, 0);
    cyc();
    idle();
    checks++;
    if ({rr_ex_rd, rr_ex_reg_wr, rr_ex_is_load} !== {3'd3, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL lat_rr_ex: got rd=%0d wr=%0b ld=%0b expected 3/1/0",
                         rr_ex_rd, rr_ex_reg_wr, rr_ex_is_load);
    end
    cyc();
    checks++;
    if ({ex_mr_rd, ex_mr_reg_wr, rr_ex_reg_wr} !== {3'd3, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL lat_ex_mr: got rd=%0d wr=%0b s1wr=%0b expected 3/1/0",
                         ex_mr_rd, ex_mr_reg_wr, rr_ex_reg_wr);
    end
    cyc();
    checks++;
    if ({mr_wb_rd, mr_wb_reg_wr, ex_mr_reg_wr} !== {3'd3, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL lat_mr_wb: got rd=%0d wr=%0b s2wr=%0b expected 3/1/0",
                         mr_wb_rd, mr_wb_reg_wr, ex_mr_reg_wr);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd4, 1, 0, 3'd2, 1, 3'd1, 1);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL lu_stall: got %0b expected 1", stall);
    end
    cyc();
    checks++;
    if ({stall, rr_ex_reg_wr, ex_mr_rd, ex_mr_reg_wr} !== {1'b0, 1'b0, 3'd2, 1'b1}) begin
      errors++; $display("[TB] FAIL lu_bubble: got stall=%0b s1wr=%0b s2rd=%0d s2wr=%0b expected 0/0/2/1",
                         stall, rr_ex_reg_wr, ex_mr_rd, ex_mr_reg_wr);
    end
    checks++;
    if (stall_count !== 16'd1) begin
      errors++; $display("[TB] FAIL lu_count: got %0d expected 1", stall_count);
    end
    cyc();
    idle();
    checks++;
    if ({rr_ex_rd, rr_ex_reg_wr, mr_wb_rd, mr_wb_reg_wr} !== {3'd4, 1'b1, 3'd2, 1'b1}) begin
      errors++; $display("[TB] FAIL lu_consumer_ex: got rd=%0d wr=%0b wbrd=%0d wbwr=%0b expected 4/1/2/1",
                         rr_ex_rd, rr_ex_reg_wr, mr_wb_rd, mr_wb_reg_wr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd3, 1, 1, 3'd2, 1, 3'd0, 0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_stall1: got %0b expected 1", stall);
    end
    cyc();
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_release1: got %0b expected 0", stall);
    end
    cyc();
    issue(3'd5, 1, 0, 3'd3, 1, 3'd2, 1);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_stall2: got %0b expected 1", stall);
    end
    cyc();
    checks++;
    if ({stall, stall_count} !== {1'b0, 16'd2}) begin
      errors++; $display("[TB] FAIL b2b_count: got stall=%0b count=%0d expected 0/2", stall, stall_count);
    end
    cyc();
    idle();
    checks++;
    if ({rr_ex_rd, rr_ex_reg_wr} !== {3'd5, 1'b1}) begin
      errors++; $display("[TB] FAIL b2b_consumer: got rd=%0d wr=%0b expected 5/1", rr_ex_rd, rr_ex_reg_wr);
    end
  endtask

  task automatic test_no_false_stall();
    do_reset();
    issue(3'd7, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd1, 1, 0, 3'd7, 1, 3'd0, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL nfs_r7: got %0b expected 0", stall);
    end
    issue(3'd4, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd1, 1, 0, 3'd0, 1, 3'd4, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL nfs_unused_rs2: got %0b expected 0", stall);
    end
    issue(3'd4, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd1, 1, 0, 3'd4, 1, 3'd0, 0);
    rr_valid = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL nfs_rr_invalid: got %0b expected 0", stall);
    end
    issue(3'd4, 1, 0, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd1, 1, 0, 3'd4, 1, 3'd4, 1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL nfs_alu: got %0b expected 0", stall);
    end
    cyc();
    idle();
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("[TB] FAIL nfs_count: got %0d expected 0", stall_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd6, 1, 0, 3'd2, 1, 3'd0, 0);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_stall: got %0b expected 0", stall);
    end
    cyc();
    idle();
    checks++;
    if ({rr_ex_rd, rr_ex_reg_wr, ex_mr_rd, ex_mr_reg_wr} !== {3'd0, 1'b0, 3'd2, 1'b1}) begin
      errors++; $display("[TB] FAIL flush_bubble: got s1rd=%0d s1wr=%0b s2rd=%0d s2wr=%0b expected 0/0/2/1",
                         rr_ex_rd, rr_ex_reg_wr, ex_mr_rd, ex_mr_reg_wr);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("[TB] FAIL flush_count: got %0d expected 0", stall_count);
    end
  endtask

  task automatic test_pending();
    logic [7:0] exp_p [4];
    exp_p = '{8'b0010_0010, 8'b0010_0010, 8'b0000_0010, 8'b0000_0000};
    do_reset();
    issue(3'd1, 1, 0, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd5, 1, 0, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd1, 1, 0, 3'd0, 0, 3'd0, 0);
    cyc();
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (pending !== exp_p[k]) begin
        errors++; $display("[TB] FAIL pending_step%0d: got %b expected %b", k, pending, exp_p[k]);
      end
      cyc();
    end
  endtask

  task automatic test_counter();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      issue(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);
      cyc();
      issue(3'd3, 1, 0, 3'd2, 1, 3'd0, 0);
      cyc();
    end
    idle();
    checks++;
    if (stall_count !== 16'd20) begin
      errors++; $display("[TB] FAIL cnt_wide: got %0d expected 20", stall_count);
    end
    checks++;
    if (stall_count4 !== 4'd15) begin
      errors++; $display("[TB] FAIL cnt_saturate: got %0d expected 15", stall_count4);
    end
    issue(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);
    cyc();
    issue(3'd3, 1, 0, 3'd2, 1, 3'd0, 0);
    cnt_clr = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL cnt_clr_stall: got %0b expected 1", stall);
    end
    cyc();
    idle();
    checks++;
    if ({stall_count, stall_count4} !== 20'd0) begin
      errors++; $display("[TB] FAIL cnt_clr: got %0d/%0d expected 0/0", stall_count, stall_count4);
    end
  endtask

  task automatic test_random();
    logic        hz, estall, fl, clr, vin;
    logic [7:0]  epend;
    logic [12:0] etag, otag, otag4;
    logic [15:0] ecnt;
    logic [3:0]  ecnt4;
    tag_t        nxt;
    do_reset();
    for (int s = 0; s < 3; s++) mstg[s] = '0;
    mcnt = 0;
    for (int n = 0; n < 400; n++) begin
      rr_valid    = ($urandom_range(0, 3) != 0);
      rr_rd       = ($urandom_range(0, 4) == 4) ? 3'd7 : 3'($urandom_range(0, 3));
      rr_rs1      = ($urandom_range(0, 4) == 4) ? 3'd7 : 3'($urandom_range(0, 3));
      rr_rs2      = ($urandom_range(0, 4) == 4) ? 3'd7 : 3'($urandom_range(0, 3));
      rr_reg_wr   = ($urandom_range(0, 3) != 0);
      rr_is_load  = $urandom_range(0, 1) == 1;
      rr_rs1_used = $urandom_range(0, 1) == 1;
      rr_rs2_used = $urandom_range(0, 1) == 1;
      flush       = ($urandom_range(0, 9) == 0);
      cnt_clr     = ($urandom_range(0, 29) == 0);
      #1;
      hz = mstg[0].v && mstg[0].wr && mstg[0].ld && rr_valid &&
           ((rr_rs1_used && rr_rs1 == mstg[0].rd && rr_rs1 != 3'd7) ||
            (rr_rs2_used && rr_rs2 == mstg[0].rd && rr_rs2 != 3'd7));
      estall = hz && !flush;
      epend = 8'd0;
      for (int s = 0; s < 3; s++) if (mstg[s].v && mstg[s].wr) epend[mstg[s].rd] = 1'b1;
      etag = {(mstg[0].v && mstg[0].wr) ? mstg[0].rd : 3'd0, mstg[0].v & mstg[0].wr,
              mstg[0].v & mstg[0].ld,
              (mstg[1].v && mstg[1].wr) ? mstg[1].rd : 3'd0, mstg[1].v & mstg[1].wr,
              (mstg[2].v && mstg[2].wr) ? mstg[2].rd : 3'd0, mstg[2].v & mstg[2].wr};
      otag = {rr_ex_reg_wr ? rr_ex_rd : 3'd0, rr_ex_reg_wr, rr_ex_is_load,
              ex_mr_reg_wr ? ex_mr_rd : 3'd0, ex_mr_reg_wr,
              mr_wb_reg_wr ? mr_wb_rd : 3'd0, mr_wb_reg_wr};
      otag4 = {rr_ex_reg_wr4 ? rr_ex_rd4 : 3'd0, rr_ex_reg_wr4, rr_ex_is_load4,
               ex_mr_reg_wr4 ? ex_mr_rd4 : 3'd0, ex_mr_reg_wr4,
               mr_wb_reg_wr4 ? mr_wb_rd4 : 3'd0, mr_wb_reg_wr4};
      ecnt  = (mcnt > 65535) ? 16'hFFFF : 16'(mcnt);
      ecnt4 = (mcnt > 15) ? 4'hF : 4'(mcnt);
      checks++;
      if (stall !== estall) begin
        errors++; $display("[TB] FAIL rand_stall n=%0d: got %0b expected %0b", n, stall, estall);
      end
      checks++;
      if (pending !== epend) begin
        errors++; $display("[TB] FAIL rand_pending n=%0d: got %b expected %b", n, pending, epend);
      end
      checks++;
      if (otag !== etag) begin
        errors++; $display("[TB] FAIL rand_tags n=%0d: got %b expected %b", n, otag, etag);
      end
      checks++;
      if (stall_count !== ecnt) begin
        errors++; $display("[TB] FAIL rand_count n=%0d: got %0d expected %0d", n, stall_count, ecnt);
      end
      checks++;
      if ({otag4, stall4, pending4, stall_count4} !== {etag, estall, epend, ecnt4}) begin
        errors++; $display("[TB] FAIL rand_narrow n=%0d: got %h expected %h", n,
                           {otag4, stall4, pending4, stall_count4}, {etag, estall, epend, ecnt4});
      end
      fl  = flush;
      clr = cnt_clr;
      vin = rr_valid;
      nxt = '{v: 1'b1, rd: rr_rd, wr: rr_reg_wr, ld: rr_is_load};
      @(posedge clk);
      if (clr) mcnt = 0;
      else if (estall) mcnt++;
      mstg[2] = mstg[1];
      mstg[1] = mstg[0];
      mstg[0] = (fl || hz || !vin) ? tag_t'('0) : nxt;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_latency();
    test_load_use();
    test_back_to_back();
    test_no_false_stall();
    test_flush();
    test_pending();
    test_counter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
